// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D-cache to pmem arbiter: FSM states, latched op, default widths.
// No logic of its own; zero latency.
// Not applicable (type definitions only).
package arb_types;

  localparam int ARB_ADDR_WIDTH = 32;
  localparam int ARB_LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_READ  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_op_t;

endpackage

// File: rtl/cache_arbiter_pick.sv
// Combinational I/D winner selection; last_grant=1 means D won the previous grant.
// Zero latency (pure combinational).
// No backpressure: grants are only consumed by the FSM while it is idle.
module arb_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_d,
  output logic grant_i
);

  // On a tie, the side that did not win last time goes first; with last_grant
  // tied low this collapses to fixed D-over-I priority.
  always_comb begin
    grant_d = d_req && (!i_req || !last_grant);
    grant_i = i_req && (!d_req ||  last_grant);
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one pmem line port between the I-cache and D-cache miss paths, one transaction at a time.
// Request sampled in IDLE at cycle N -> pmem strobe at N+1; resp is pmem_resp gated by the serving state.
// Requesters hold until resp; pmem strobes are held until pmem_resp. Optional ARB_ROUND_ROBIN_EN: fair tie-break.
module cache_arbiter
  import arb_types::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int LINE_WIDTH = ARB_LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t state;
  arb_op_t    win_op;
  logic       i_req;
  logic       d_req;
  logic       grant_i;
  logic       grant_d;
  logic       last_grant;

  assign i_req = i_read;
  assign d_req = d_read || d_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  // Remember which side entered service last; reset favours D.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b0;
    end else if (state == IDLE && (grant_d || grant_i)) begin
      last_grant_q <= grant_d;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = 1'b0;
`endif

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant_d    (grant_d),
    .grant_i    (grant_i)
  );

  // Op of the D winner; a simultaneous read+write resolves to the write-back.
  always_comb begin
    win_op = d_write ? ARB_WRITE : ARB_READ;
  end

  // Arbitration FSM: latch the winner in IDLE, hold strobes until pmem_resp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state        <= SERVE_D;
            pmem_address <= d_address;
            pmem_wdata   <= d_wdata;
            pmem_read    <= (win_op == ARB_READ);
            pmem_write   <= (win_op == ARB_WRITE);
          end else if (grant_i) begin
            state        <= SERVE_I;
            pmem_address <= i_address;
            pmem_wdata   <= '0;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          // Requester inputs are ignored here; the latched transaction always completes.
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Completion steering: resp only to the owner, data mirrored to both (forced low in reset).
  always_comb begin
    i_resp  = pmem_resp && (state == SERVE_I);
    d_resp  = pmem_resp && (state == SERVE_D);
    i_rdata = reset_n ? pmem_rdata : '0;
    d_rdata = reset_n ? pmem_rdata : '0;
  end

  // A D-cache asking for read and write-back at once is a protocol error.
  property p_no_dual_d_op;
    @(posedge clk) disable iff (!reset_n) (state == IDLE) |-> !(d_read && d_write);
  endproperty
  a_no_dual_d_op: assert property (p_no_dual_d_op);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter with hand-computed expectations.
// Inputs change 2ns after a rising edge; outputs are sampled there or 1ns after an input change.
// Memory responses are driven inline by each scenario task.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  localparam logic [LW-1:0] PAT_A = {8{32'hA5A5_0001}};
  localparam logic [LW-1:0] PAT_B = {8{32'h5A5A_0002}};
  localparam logic [LW-1:0] PAT_C = {8{32'hC3C3_0003}};
  localparam logic [LW-1:0] PAT_D = {8{32'h3C3C_0004}};

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int total = 0;
  int bad   = 0;

  cache_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    #3;
    total++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin bad++; $display("FAIL reset_strobes got rd=%b wr=%b exp 0 0", pmem_read, pmem_write); end
    total++; if (pmem_address !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", pmem_address); end
    total++; if (pmem_wdata !== '0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", pmem_wdata); end
    total++; if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== '0 || d_rdata !== '0) begin bad++; $display("FAIL reset_resp got i=%b d=%b exp 0 0", i_resp, d_resp); end
    tick();
    reset_n = 1'b1;
    tick();
    total++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin bad++; $display("FAIL idle_no_req got rd=%b wr=%b exp 0 0", pmem_read, pmem_write); end
  endtask

  task automatic test_i_read();
    i_read = 1'b1; i_address = 32'h0000_0040;
    #1;
    total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL iread_idle_strobe got=%b exp=0", pmem_read); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin bad++; $display("FAIL iread_strobe cyc%0d got rd=%b wr=%b exp 1 0", k, pmem_read, pmem_write); end
      total++; if (pmem_address !== 32'h40) begin bad++; $display("FAIL iread_addr cyc%0d got=%h exp=00000040", k, pmem_address); end
      if (k == 3) begin
        pmem_resp = 1'b1; pmem_rdata = PAT_A;
      end
      #1;
      total++; if (i_resp !== (k == 3)) begin bad++; $display("FAIL iread_resp cyc%0d got=%b exp=%b", k, i_resp, (k == 3)); end
      total++; if (d_resp !== 1'b0) begin bad++; $display("FAIL iread_dresp cyc%0d got=%b exp=0", k, d_resp); end
    end
    total++; if (i_rdata !== PAT_A) begin bad++; $display("FAIL iread_rdata got=%h exp=%h", i_rdata, PAT_A); end
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
    #1;
    total++; if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin bad++; $display("FAIL iread_done got rd=%b resp=%b exp 0 0", pmem_read, i_resp); end
  endtask

  task automatic test_d_write();
    d_write = 1'b1; d_address = 32'h0000_1000; d_wdata = PAT_B;
    tick();
    total++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin bad++; $display("FAIL dwr_strobe got rd=%b wr=%b exp 0 1", pmem_read, pmem_write); end
    total++; if (pmem_address !== 32'h1000) begin bad++; $display("FAIL dwr_addr got=%h exp=00001000", pmem_address); end
    total++; if (pmem_wdata !== PAT_B) begin bad++; $display("FAIL dwr_wdata got=%h exp=%h", pmem_wdata, PAT_B); end
    pmem_resp = 1'b1; pmem_rdata = '0;
    #1;
    total++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin bad++; $display("FAIL dwr_resp got d=%b i=%b exp 1 0", d_resp, i_resp); end
    tick();
    pmem_resp = 1'b0; d_write = 1'b0;
    #1;
    total++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || d_resp !== 1'b0) begin bad++; $display("FAIL dwr_done got rd=%b wr=%b resp=%b exp 0 0 0", pmem_read, pmem_write, d_resp); end
  endtask

  task automatic test_simultaneous();
    i_read = 1'b1; i_address = 32'h0000_0080;
    d_read = 1'b1; d_address = 32'h0000_2000;
    tick();
    total++; if (pmem_read !== 1'b1 || pmem_address !== 32'h2000) begin bad++; $display("FAIL sim_first got rd=%b addr=%h exp 1 00002000", pmem_read, pmem_address); end
    pmem_resp = 1'b1; pmem_rdata = PAT_C;
    #1;
    total++; if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== PAT_C) begin bad++; $display("FAIL sim_dresp got d=%b i=%b exp 1 0", d_resp, i_resp); end
    tick();
    pmem_resp = 1'b0; d_read = 1'b0;
    total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL sim_idle_gap got rd=%b exp=0", pmem_read); end
    tick();
    total++; if (pmem_read !== 1'b1 || pmem_address !== 32'h80) begin bad++; $display("FAIL sim_second got rd=%b addr=%h exp 1 00000080", pmem_read, pmem_address); end
    pmem_resp = 1'b1; pmem_rdata = PAT_D;
    #1;
    total++; if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== PAT_D) begin bad++; $display("FAIL sim_iresp got i=%b d=%b exp 1 0", i_resp, d_resp); end
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
  endtask

  // D keeps requesting while I waits; grant order depends on the tie-break build.
  task automatic test_contention();
    logic [AW-1:0] exp_addr [3];
    logic          exp_d    [3];
`ifdef ARB_ROUND_ROBIN_EN
    exp_addr = '{32'h2000, 32'h80, 32'h2000};
    exp_d    = '{1'b1, 1'b0, 1'b1};
`else
    exp_addr = '{32'h2000, 32'h2000, 32'h80};
    exp_d    = '{1'b1, 1'b1, 1'b0};
`endif
    reset_n = 1'b0;
    #1;
    tick();
    reset_n = 1'b1;
    i_read = 1'b1; i_address = 32'h0000_0080;
    d_read = 1'b1; d_address = 32'h0000_2000;
    for (int g = 0; g < 3; g++) begin
      tick();
      total++; if (pmem_read !== 1'b1 || pmem_address !== exp_addr[g]) begin bad++; $display("FAIL cont_grant%0d got rd=%b addr=%h exp 1 %h", g, pmem_read, pmem_address, exp_addr[g]); end
      pmem_resp = 1'b1; pmem_rdata = PAT_A;
      #1;
      total++; if (d_resp !== exp_d[g] || i_resp !== !exp_d[g]) begin bad++; $display("FAIL cont_resp%0d got d=%b i=%b exp %b %b", g, d_resp, i_resp, exp_d[g], !exp_d[g]); end
      tick();
      pmem_resp = 1'b0;
      if (!exp_d[g]) i_read = 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
      if (g == 1) d_read = 1'b0;
`endif
    end
    d_read = 1'b0; i_read = 1'b0;
  endtask

  task automatic test_reset_mid();
    d_read = 1'b1; d_address = 32'h0000_3000;
    tick();
    total++; if (pmem_read !== 1'b1 || pmem_address !== 32'h3000) begin bad++; $display("FAIL rst_pre got rd=%b addr=%h exp 1 00003000", pmem_read, pmem_address); end
    tick();
    reset_n = 1'b0; pmem_resp = 1'b1; pmem_rdata = PAT_B;
    #1;
    total++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_address !== '0 || pmem_wdata !== '0) begin bad++; $display("FAIL rst_mid_pmem got rd=%b wr=%b addr=%h exp 0 0 0", pmem_read, pmem_write, pmem_address); end
    total++; if (d_resp !== 1'b0 || i_resp !== 1'b0 || d_rdata !== '0 || i_rdata !== '0) begin bad++; $display("FAIL rst_mid_resp got d=%b i=%b exp 0 0", d_resp, i_resp); end
    tick();
    reset_n = 1'b1; pmem_resp = 1'b0;
    tick();
    total++; if (pmem_read !== 1'b1 || pmem_address !== 32'h3000) begin bad++; $display("FAIL rst_regrant got rd=%b addr=%h exp 1 00003000", pmem_read, pmem_address); end
    pmem_resp = 1'b1;
    #1;
    total++; if (d_resp !== 1'b1) begin bad++; $display("FAIL rst_regrant_resp got=%b exp=1", d_resp); end
    tick();
    pmem_resp = 1'b0; d_read = 1'b0;
  endtask

  task automatic test_addr_change();
    i_read = 1'b1; i_address = 32'h0000_0100;
    tick();
    total++; if (pmem_address !== 32'h100) begin bad++; $display("FAIL achg_latch got=%h exp=00000100", pmem_address); end
    i_address = 32'hFFFF_0000;
    tick();
    total++; if (pmem_address !== 32'h100 || pmem_read !== 1'b1) begin bad++; $display("FAIL achg_hold1 got addr=%h rd=%b exp 00000100 1", pmem_address, pmem_read); end
    tick();
    total++; if (pmem_address !== 32'h100) begin bad++; $display("FAIL achg_hold2 got=%h exp=00000100", pmem_address); end
    pmem_resp = 1'b1; pmem_rdata = PAT_C;
    #1;
    total++; if (i_resp !== 1'b1 || i_rdata !== PAT_C) begin bad++; $display("FAIL achg_resp got=%b exp=1", i_resp); end
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
`ifndef ARB_ROUND_ROBIN_EN
    test_simultaneous();
`endif
    test_contention();
    test_reset_mid();
    test_addr_change();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory (L2/pmem) line port between the I-cache miss path and the D-cache miss path of the pipelined rv32i core.
- Each cache presents a line-granular read or write-back request and holds it until the arbiter returns resp.
- Serves one transaction at a time: latches the winner's request, drives pmem, steers the response back.
- Sits between the two L1 caches and the memory/L2 interface.

Parameters:
- ADDR_WIDTH, 32, byte address width of requests and pmem.
- LINE_WIDTH, 256, cache line width in bits for wdata/rdata.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_read  input  1  I-cache line read request, held until i_resp.
- i_address  input  ADDR_WIDTH  I-cache line address.
- i_rdata  output  LINE_WIDTH  line returned to the I-cache.
- i_resp  output  1  one-cycle completion pulse to the I-cache.
- d_read  input  1  D-cache line read request, held until d_resp.
- d_write  input  1  D-cache write-back request, held until d_resp.
- d_address  input  ADDR_WIDTH  D-cache line address.
- d_wdata  input  LINE_WIDTH  D-cache write-back line.
- d_rdata  output  LINE_WIDTH  line returned to the D-cache.
- d_resp  output  1  one-cycle completion pulse to the D-cache.
- pmem_read  output  1  memory read strobe, held until pmem_resp.
- pmem_write  output  1  memory write strobe, held until pmem_resp.
- pmem_address  output  ADDR_WIDTH  latched line address.
- pmem_wdata  output  LINE_WIDTH  latched write line.
- pmem_rdata  input  LINE_WIDTH  memory read data, valid with pmem_resp.
- pmem_resp  input  1  memory completion, one cycle.

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D.
- Reset (async, reset_n=0):
  - state=IDLE.
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - i_resp=0, d_resp=0, i_rdata=0, d_rdata=0.
  - The priority pointer (if present) is cleared to favour D.
- IDLE:
  - Samples requests each cycle.
  - Fixed priority: D (d_read|d_write) beats I (i_read).
  - On a win, registers address, op (read/write) and wdata, then enters SERVE_D or SERVE_I at the next edge.
  - No pmem strobe is asserted in IDLE.
- SERVE_x:
  - pmem_read/pmem_write are driven from the latched op; address and wdata are stable for the whole transaction.
  - Input changes are ignored while serving. Dropping a request mid-service is a protocol violation: the latched transaction still completes, and resp still pulses.
- Completion:
  - x_resp = pmem_resp & (state==SERVE_x), combinational.
  - x_rdata = pmem_rdata, passthrough.
  - On pmem_resp the FSM returns to IDLE at the next edge.
- Latency:
  - Request sampled in IDLE at cycle N gives a pmem strobe in cycle N+1.
  - With zero-wait memory, resp arrives in cycle N+1 and the next grant is possible at cycle N+2.
  - The minimum IDLE cycle between transactions is mandatory; no back-to-back pmem strobes.
- Simultaneous events:
  - I and D requesting in the same IDLE cycle: D is granted, I waits and is granted in the next IDLE cycle unless D requests again (starvation possible without the optional feature).
  - d_read & d_write both high is illegal: write wins, and a simulation assertion fires.
- Unselected requester: its resp is held 0 and its rdata still mirrors pmem_rdata (don't-care).
- Reset asserted mid-transaction: abandons it immediately, all strobes low, no resp emitted.

Optional Feature:
- ARB_ROUND_ROBIN_EN.
- Defined:
  - One-bit last-grant register.
  - On simultaneous I/D requests in IDLE, the requester not granted last wins.
  - Bounds either side's wait to one transaction.
  - Last-grant updates on each entry to SERVE_x.
- Undefined: fixed D-over-I priority as above; no pointer flop.

Decomposition:
- Shared package arb_types:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D}.
  - arb_op_t enum {ARB_READ, ARB_WRITE}.
  - Default LINE_WIDTH/ADDR_WIDTH constants.
- Sub-module arb_pick: combinational winner selection.
  - Inputs: i_req, d_req, last_grant.
  - Output: grant_d, grant_i.
- The FSM and latches stay in cache_arbiter.

Test Plan:
- Single I read, addr 0x00000040, pmem_resp after 3 cycles with rdata pattern A:
  - pmem_read=1 with pmem_address=0x40 for exactly those cycles.
  - i_resp pulses once with i_rdata=A; d_resp stays 0.
- D write-back, addr 0x00001000, wdata pattern B:
  - pmem_write=1, pmem_wdata=B, pmem_address=0x1000.
  - d_resp one pulse; pmem_read never asserted.
- I read 0x80 and D read 0x2000 raised in the same cycle (macro off):
  - D served first (pmem_address=0x2000), then one IDLE cycle, then I (0x80).
  - Each resp is routed only to its owner.
- Macro on, D requests continuously while I waits:
  - Grants alternate D, I, D.
  - I completes within 2 transactions.
- reset_n low during SERVE_D at cycle 2 of a 5-cycle memory wait:
  - All outputs 0 immediately, state IDLE, no d_resp.
  - After reset release, the held D request is re-granted.
- i_address changed to 0xFFFF0000 mid-SERVE_I:
  - pmem_address stays at the originally latched value until pmem_resp.
